// File: rtl/net_output_stage.sv
// Output stage after the network: serial saturating left-shift of a D-channel result,
// double-buffered and committed to the DAC outputs on sample_tick. Counters need NET_OUT_STATS_EN.
module net_output_stage #(
  parameter int unsigned W     = 16,
  parameter int unsigned D     = 4,
  parameter int unsigned SHIFT = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D*W-1:0] in_data,
  input  logic           sample_tick,
  input  logic [D-1:0]   mute,
  output logic [D*W-1:0] sample_out,
  output logic           out_strobe,
  output logic [15:0]    underrun_cnt,
  output logic [15:0]    drop_cnt
);

  localparam int unsigned IdxW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(D - 1);

  typedef enum logic [1:0] {StIdle, StScale, StPublish} state_e;

  state_e          state_q;
  logic [IdxW-1:0] chan_idx_q;
  logic [W-1:0]    work_q   [D];
  logic [W-1:0]    staged_q [D];
  logic            staged_valid_q;

  // Shared saturating shifter: the result fits in W bits iff the top SHIFT+1 bits agree.
  logic signed [W-1:0]       sh_in;
  logic signed [W+SHIFT-1:0] sh_wide;
  logic [SHIFT:0]            sh_top;
  logic [W-1:0]              sh_out;

  assign sh_in   = work_q[chan_idx_q];
  assign sh_wide = (W+SHIFT)'(sh_in) <<< SHIFT;
  assign sh_top  = sh_wide[W+SHIFT-1:W-1];

  always_comb begin
    sh_out = sh_wide[W-1:0];
    if (!((&sh_top) || !(|sh_top))) begin
      sh_out = sh_top[SHIFT] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  logic publish;
  logic commit;
  assign publish = (state_q == StPublish);
  assign commit  = sample_tick && staged_valid_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      in_ready       <= 1'b1;
      chan_idx_q     <= '0;
      staged_valid_q <= 1'b0;
      sample_out     <= '0;
      out_strobe     <= 1'b0;
    end else begin
      out_strobe <= commit;
      if (commit) begin
        for (int i = 0; i < int'(D); i++) begin
          sample_out[(D-1-i)*W +: W] <= mute[i] ? '0 : staged_q[i];
        end
      end
      // A publish coinciding with a commit refills the buffer, so valid stays set.
      if (publish) begin
        staged_valid_q <= 1'b1;
      end else if (sample_tick) begin
        staged_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            chan_idx_q <= '0;
            in_ready   <= 1'b0;
            state_q    <= StScale;
          end
        end
        StScale: begin
          chan_idx_q <= chan_idx_q + 1'b1;
          if (chan_idx_q == LastIdx) begin
            state_q <= StPublish;
          end
        end
        StPublish: begin
          in_ready <= 1'b1;
          state_q  <= StIdle;
        end
        default: begin
          in_ready <= 1'b1;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  // Datapath regs carry no reset; staged_valid_q gates any stale contents.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && in_valid) begin
      for (int i = 0; i < int'(D); i++) begin
        work_q[i] <= in_data[(D-1-i)*W +: W];
      end
    end else if (state_q == StScale) begin
      work_q[chan_idx_q] <= sh_out;
    end
    if (publish) begin
      for (int i = 0; i < int'(D); i++) begin
        staged_q[i] <= work_q[i];
      end
    end
  end

`ifdef NET_OUT_STATS_EN
  logic [15:0] underrun_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      underrun_q <= '0;
      drop_q     <= '0;
    end else begin
      if (sample_tick && !staged_valid_q && underrun_q != 16'hFFFF) begin
        underrun_q <= underrun_q + 16'd1;
      end
      if (publish && staged_valid_q && !sample_tick && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign underrun_cnt = underrun_q;
  assign drop_cnt     = drop_q;
`else
  assign underrun_cnt = '0;
  assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_net_output_stage.sv
// Directed and random checks of net_output_stage against a transaction-level model
// of the staging buffer, commit and counter rules.
module tb_net_output_stage;
  localparam int W     = 16;
  localparam int D     = 4;
  localparam int SHIFT = 2;
`ifdef NET_OUT_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [D*W-1:0] in_data = '0;
  logic           sample_tick = 1'b0;
  logic [D-1:0]   mute = '0;
  logic [D*W-1:0] sample_out;
  logic           out_strobe;
  logic [15:0]    underrun_cnt;
  logic [15:0]    drop_cnt;

  net_output_stage #(.W(W), .D(D), .SHIFT(SHIFT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .sample_tick  (sample_tick),
    .mute         (mute),
    .sample_out   (sample_out),
    .out_strobe   (out_strobe),
    .underrun_cnt (underrun_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0]   m_staged [D];
  bit             m_sv;
  logic [D*W-1:0] m_out;
  bit             m_strobe;
  int             m_under;
  int             m_drop;

  function automatic logic [W-1:0] ref_sat(logic [W-1:0] x);
    longint v;
    longint hi;
    v  = longint'($signed(x)) * (longint'(1) << SHIFT);
    hi = (longint'(1) << (W - 1)) - 1;
    if (v > hi) v = hi;
    if (v < -(hi + 1)) v = -(hi + 1);
    return v[W-1:0];
  endfunction

  function automatic logic [W-1:0] chan(logic [D*W-1:0] p, int i);
    return p[(D-1-i)*W +: W];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, " sample_out"}, 64'(sample_out), 64'(m_out));
    check({tag, " out_strobe"}, 64'(out_strobe), 64'(m_strobe));
    check({tag, " underrun"}, 64'(underrun_cnt), StatsEn ? 64'(m_under) : 64'd0);
    check({tag, " drop"}, 64'(drop_cnt), StatsEn ? 64'(m_drop) : 64'd0);
  endtask

  task automatic model_reset();
    m_sv = 0; m_out = '0; m_strobe = 0; m_under = 0; m_drop = 0;
  endtask

  task automatic model_publish(logic [D*W-1:0] d, bit coincident_tick);
    if (m_sv && !coincident_tick && m_drop < 65535) m_drop++;
    for (int i = 0; i < D; i++) m_staged[i] = ref_sat(chan(d, i));
    m_sv = 1;
  endtask

  task automatic model_tick();
    if (m_sv) begin
      for (int i = 0; i < D; i++) m_out[(D-1-i)*W +: W] = mute[i] ? '0 : m_staged[i];
      m_strobe = 1;
      m_sv = 0;
    end else begin
      if (m_under < 65535) m_under++;
      m_strobe = 0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Handshake, then let the result publish; optionally tick on the publish edge.
  task automatic send(logic [D*W-1:0] d, bit tick_at_pub);
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", 64'(in_ready), 64'd0);
    repeat (D) @(negedge clk);
    if (tick_at_pub) sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    if (tick_at_pub) model_tick();
    else m_strobe = 0;
    model_publish(d, tick_at_pub);
    check("ready_after_publish", 64'(in_ready), 64'd1);
    check_all("send");
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    model_tick();
    check_all("tick");
    @(negedge clk);
    m_strobe = 0;
    check("strobe_one_cycle", 64'(out_strobe), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("reset");
    check("reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [D*W-1:0] a;
    logic [D*W-1:0] b;

    do_reset();

    // Underrun from empty
    repeat (3) tick();

    // Passthrough
    send({16'h0100, 16'hFF00, 16'h0001, 16'h0000}, 1'b0);
    tick();
    check("pass_literal", 64'(sample_out), 64'h0400_FC00_0004_0000);

    // Saturation
    send({16'h2000, 16'hE000, 16'h1FFF, 16'hDFFF}, 1'b0);
    tick();
    check("sat_literal", 64'(sample_out), 64'h7FFF_8000_7FFC_8000);

    for (int k = 0; k < 6; k++) begin
      a = {$urandom, $urandom};
      send(a, 1'b0);
      tick();
    end

    // Drop: second publish overwrites the first
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    send(a, 1'b0);
    send(b, 1'b0);
    tick();

    // Backpressure: b held on in_valid through SCALE, taken in first IDLE cycle
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    wait_ready();
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    in_data = b;
    check("bp busy", 64'(in_ready), 64'd0);
    repeat (D) @(negedge clk);
    check("bp publish busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    model_publish(a, 1'b0);
    m_strobe = 0;
    check("bp idle ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second taken", 64'(in_ready), 64'd0);
    repeat (D + 1) @(negedge clk);
    model_publish(b, 1'b0);
    check_all("bp");
    tick();

    // Mute channel 2
    mute = 4'b0100;
    a = {$urandom, $urandom};
    send(a, 1'b0);
    tick();
    check("mute ch2", 64'(chan(sample_out, 2)), 64'd0);
    mute = '0;

    // Tick coincident with publish, staged empty: underrun then commit
    a = {$urandom, $urandom};
    send(a, 1'b1);
    tick();

    // Tick coincident with publish, staged full: old commits, new stays, no drop
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    send(a, 1'b0);
    send(b, 1'b1);
    tick();

    // Reset during SCALE
    a = {$urandom, $urandom};
    wait_ready();
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check_all("mid_scale_reset");
    check("mid_scale_reset in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset in_ready", 64'(in_ready), 64'd1);
    b = {$urandom, $urandom};
    send(b, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
